led_event_stretcher: RTL

- Output-side companion to the button input path: takes clean one-cycle internal event pulses and drives physical LEDs so each event is a human-visible blink.
- Each channel stretches an event to a fixed ON time, then enforces a dark GAP so back-to-back events show as separate blinks.
- Events arriving while a channel is busy are queued in a saturating counter; queue overflow is flagged.
- Sits between control logic (e.g. debounced button pulses, FSM events) and the board LED pins.

---
 rtl/led_stretch_pkg.sv | 16 +
 rtl/led_stretch_ch.sv | 109 ++++++++++
 rtl/led_event_stretcher.sv | 57 +++++
 3 files changed

// File: rtl/led_stretch_pkg.sv
// Shared constants and state encoding for the LED event stretcher.
// Optional PWM dimming is enabled with LED_STRETCH_PWM_EN.
package led_stretch_pkg;

  localparam int ON_CYCLES_DEF  = 12500000;
  localparam int GAP_CYCLES_DEF = 6250000;
  localparam int CNT_W_DEF      = 24;
  localparam int PEND_W_DEF     = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ON   = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

endpackage

// File: rtl/led_stretch_ch.sv
// One LED channel: blink FSM, shared ON/GAP timer, pend queue
// and sticky overflow flag.
module led_stretch_ch
  import led_stretch_pkg::*;
#(
  parameter int ON_CYCLES  = ON_CYCLES_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PEND_W     = PEND_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_evt,
  input  logic i_clr,
  input  logic i_pwm_on,
  output logic o_led,
  output logic o_busy,
  output logic o_ovf
);

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_timer;
  logic [CNT_W-1:0]  w_timer_nxt;
  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_nxt;
  logic              w_queue;
  logic              w_ovf_set;
  logic              r_ovf;
  logic              r_led;
  logic              r_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pend_nxt  = r_pend;
    w_queue     = 1'b0;
    w_ovf_set   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_evt) begin
          w_state_nxt = ST_ON;
          w_timer_nxt = '0;
        end
      end
      ST_ON: begin
        w_queue = i_evt;
        if (r_timer == ON_LAST) begin
          w_state_nxt = ST_GAP;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_timer == GAP_LAST) begin
          w_timer_nxt = '0;
          // a queued blink wins; a same-cycle event replaces it in the queue
          if (r_pend != '0) begin
            w_state_nxt = ST_ON;
            if (!i_evt) w_pend_nxt = r_pend - 1'b1;
          end else if (i_evt) begin
            w_state_nxt = ST_ON;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
          w_queue     = i_evt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase
    if (w_queue) begin
      if (r_pend == PEND_MAX) w_ovf_set = 1'b1;
      else                    w_pend_nxt = r_pend + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_set | (r_ovf & ~i_clr);
      r_led   <= (w_state_nxt == ST_ON) & i_pwm_on;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_led  = r_led;
  assign o_busy = r_busy;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/led_event_stretcher.sv
// N_CH independent LED blink stretchers with event queueing.
// Define LED_STRETCH_PWM_EN to add a shared 4-bit duty dimmer.
module led_event_stretcher
  import led_stretch_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int ON_CYCLES  = ON_CYCLES_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PEND_W     = PEND_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] evt_in,
  input  logic [N_CH-1:0] clr_overflow,
`ifdef LED_STRETCH_PWM_EN
  input  logic [3:0]      duty,
`endif
  output logic [N_CH-1:0] led_out,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] overflow
);

  logic w_pwm_on;

`ifdef LED_STRETCH_PWM_EN
  logic [3:0] r_pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  assign w_pwm_on = (r_pwm_cnt < duty);
`else
  assign w_pwm_on = 1'b1;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_stretch_ch #(
      .ON_CYCLES  (ON_CYCLES),
      .GAP_CYCLES (GAP_CYCLES),
      .CNT_W      (CNT_W),
      .PEND_W     (PEND_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_evt    (evt_in[g]),
      .i_clr    (clr_overflow[g]),
      .i_pwm_on (w_pwm_on),
      .o_led    (led_out[g]),
      .o_busy   (busy[g]),
      .o_ovf    (overflow[g])
    );
  end

endmodule
